button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable synchronized samples required to accept a new button level (>=2).
REQ-002 Parameter HOLD_CYCLES, default 27500000, minimum press duration in Holdstart before a release may start timing (>=1).
REQ-003 clock  input  1  single clock, all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-006 state  input  2  current timer state from the downstream state machine: 00 Idle, 01 Inspection, 10 Holdstart, 11 Timing.
REQ-007 swotch  output  1  one-cycle advance pulse to the downstream state machine.
REQ-008 pressed  output  1  debounced button level.
REQ-009 ready  output  1  hold satisfied in Holdstart, for the "release to start" LED.

Function
REQ-010 button SHALL pass through a 2-flop synchronizer; the second-flop output is s.
REQ-011 Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)) SHALL clear on any cycle with s == pressed and SHALL increment on each cycle with s != pressed.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and s != pressed, pressed SHALL take the value of s and the counter SHALL clear; pressed changes exactly DEBOUNCE_CYCLES cycles after s changes and stays stable.
REQ-013 Any glitch on s shorter than DEBOUNCE_CYCLES cycles SHALL NOT change pressed.
REQ-014 Press event = pressed rose on the previous edge; release event = pressed fell on the previous edge. The edge register is pressed_d.
REQ-015 swotch SHALL be registered and SHALL be high for exactly the one cycle after pressed changes, when the event qualifies.
REQ-016 Qualifying events: Idle = press; Inspection = press; Timing = press; Holdstart = release with hold_cnt == HOLD_CYCLES.
REQ-017 Releases in Idle, Inspection and Timing SHALL NOT pulse. Presses in Holdstart SHALL NOT pulse.
REQ-018 In Holdstart, a release with hold_cnt < HOLD_CYCLES SHALL NOT pulse. state remains Holdstart, and the next press restarts the hold.
REQ-019 hold_cnt (width $clog2(HOLD_CYCLES+1)) SHALL increment each cycle state==10 and pressed==1, and SHALL saturate at HOLD_CYCLES.
REQ-020 hold_cnt SHALL clear on any cycle with state!=10 or pressed==0.
REQ-021 ready SHALL equal (state==10 && pressed && hold_cnt==HOLD_CYCLES), registered.
REQ-022 The end-to-end latency from a stable button change to swotch SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-023 At most one swotch pulse SHALL occur per debounced edge. Because each event lasts one cycle, the one-cycle lag of state behind swotch SHALL cause no double advance.
REQ-024 If state changes externally in the same cycle as an event, classification SHALL use the state value sampled in that cycle.

Reset
REQ-025 While reset is high, the synchronizer flops, pressed, pressed_d, the debounce counter, hold_cnt, swotch and ready SHALL all be 0 on the next edge.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard progress.
REQ-027 After reset, a button already held SHALL be seen as a fresh press after DEBOUNCE_CYCLES+3 cycles.

Configuration
REQ-028 With macro HOLD_CHECK_EN defined, Holdstart releases SHALL follow REQ-018, and hold_cnt and ready SHALL be implemented.
REQ-029 Without HOLD_CHECK_EN, any Holdstart release SHALL pulse swotch, hold_cnt SHALL be omitted, and ready SHALL equal (state==10 && pressed).

Verification
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
REQ-030 Reset: hold reset 3 cycles with button=1 -> all outputs 0; after release of reset, pressed=1 after 6 cycles and swotch pulses at cycle 7 with state=00.
REQ-031 Glitch: state=00, button high for 3 cycles then low -> pressed, swotch stay 0.
REQ-032 Full cycle: press in 00 -> one swotch. Release in 01 -> none. Press in 01 -> swotch, TB sets state=10. Hold 15 cycles -> ready=1. Release -> one swotch, ready=0.
REQ-033 Early release, HOLD_CHECK_EN defined: state=10, pressed held 6 cycles, release -> no swotch, ready never 1. Re-press held 12 cycles, release -> swotch.
REQ-034 Stop: state=11, press -> swotch exactly 7 cycles after button rises. Release -> no swotch.
REQ-035 Without HOLD_CHECK_EN: state=10, press 2 cycles past debounce, then release -> swotch pulses.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce, edge classification
// against the downstream timer state. Optional hold check is enabled by HOLD_CHECK_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 27500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic [1:0] state,
  output logic       swotch,
  output logic       pressed,
  output logic       ready
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_INSPECT = 2'b01;
  localparam logic [1:0] ST_HOLD    = 2'b10;
  localparam logic [1:0] ST_TIMING  = 2'b11;

  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  logic          sync1, s;
  logic          pressed_d;
  logic [DW-1:0] db_cnt;
  logic          rise, fall, in_hold;
  logic          hold_ok, ready_d, fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= button;
      s     <= sync1;
    end
  end

  // Counter tracks how long s has disagreed with the accepted level.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (s == pressed) begin
      db_cnt  <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      pressed <= s;
    end else begin
      db_cnt  <= db_cnt + DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) pressed_d <= 1'b0;
    else       pressed_d <= pressed;
  end

  assign rise    = pressed & ~pressed_d;
  assign fall    = ~pressed & pressed_d;
  assign in_hold = (state == ST_HOLD);

`ifdef HOLD_CHECK_EN
  localparam int            HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  assign hold_done = (hold_cnt == HOLD_MAX);

  // hold_cnt still holds the pre-release count in the release event cycle.
  always_ff @(posedge clock) begin
    if (reset || !in_hold || !pressed) hold_cnt <= '0;
    else if (!hold_done)               hold_cnt <= hold_cnt + HW'(1);
  end

  assign hold_ok = hold_done;
  assign ready_d = in_hold & pressed & hold_done;
`else
  assign hold_ok = 1'b1;
  assign ready_d = in_hold & pressed;
`endif

  always_comb begin
    fire = 1'b0;
    case (state)
      ST_IDLE, ST_INSPECT, ST_TIMING: fire = rise;
      ST_HOLD:                        fire = fall & hold_ok;
      default:                        fire = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      swotch <= 1'b0;
      ready  <= 1'b0;
    end else begin
      swotch <= fire;
      ready  <= ready_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button/state traffic
// checked every cycle against a window-based reference model.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic       clock = 1'b0;
  logic       reset, button;
  logic [1:0] state;
  logic       swotch, pressed, ready;

  always #5 clock = ~clock;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .button(button), .state(state),
    .swotch(swotch), .pressed(pressed), .ready(ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sw_seen = 0;

  // Reference model: button delayed through two samples, a window of the last
  // DEB synchronized samples, and a count of consecutive held cycles in Holdstart.
  logic m_sync1 = 1'b0, m_s = 1'b0, m_p = 1'b0, m_pd = 1'b0, m_sw = 1'b0, m_rdy = 1'b0;
  logic sh[$];
  int   m_run = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic nsync1, ns, np, npd, nsw, nrdy, rise, fall, ok, all_diff;
    int   nrun;
    if (reset) begin
      nsync1 = 0; ns = 0; np = 0; npd = 0; nsw = 0; nrdy = 0; nrun = 0;
      sh.delete();
    end else begin
      nsync1 = button;
      ns     = m_sync1;
      sh.push_back(m_s);
      if (sh.size() > DEB) void'(sh.pop_front());
      np = m_p;
      if (sh.size() == DEB) begin
        all_diff = 1'b1;
        foreach (sh[i]) if (sh[i] == m_p) all_diff = 1'b0;
        if (all_diff) np = ~m_p;
      end
      npd  = m_p;
      rise = m_p && !m_pd;
      fall = !m_p && m_pd;
`ifdef HOLD_CHECK_EN
      ok   = (m_run == HOLD);
      nrdy = (state == 2'b10) && m_p && (m_run == HOLD);
`else
      ok   = 1'b1;
      nrdy = (state == 2'b10) && m_p;
`endif
      nsw  = (state == 2'b10) ? (fall && ok) : rise;
      nrun = (state == 2'b10 && m_p) ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
    end
    @(posedge clock);
    m_sync1 = nsync1; m_s = ns; m_p = np; m_pd = npd; m_sw = nsw; m_rdy = nrdy; m_run = nrun;
    #1;
    chk("pressed", int'(pressed), int'(m_p));
    chk("swotch",  int'(swotch),  int'(m_sw));
    chk("ready",   int'(ready),   int'(m_rdy));
    if (swotch === 1'b1) sw_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t_press, t_sw, base, rdy_seen;
    reset = 1'b1; button = 1'b1; state = 2'b00;

    // Reset held with the button already down
    ticks(3);
    chk("rst_pressed", int'(pressed), 0);
    chk("rst_swotch",  int'(swotch),  0);
    chk("rst_ready",   int'(ready),   0);
    reset = 1'b0;
    t_press = -1; t_sw = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pressed === 1'b1 && t_press < 0) t_press = k;
      if (swotch === 1'b1 && t_sw < 0) t_sw = k;
    end
    chk("rst_press_lat", t_press, DEB + 2);
    chk("rst_sw_lat",    t_sw,    DEB + 3);
    button = 1'b0; ticks(10);

    // Short glitch in Idle
    base = sw_seen;
    button = 1'b1; ticks(3);
    button = 1'b0; ticks(10);
    chk("glitch_sw", sw_seen - base, 0);
    chk("glitch_pressed", int'(pressed), 0);

    // Full sequence: Idle press, Inspection release/press, Holdstart hold and release
    base = sw_seen; button = 1'b1; ticks(10);
    chk("idle_press_sw", sw_seen - base, 1);
    state = 2'b01;
    base = sw_seen; button = 1'b0; ticks(10);
    chk("insp_release_sw", sw_seen - base, 0);
    base = sw_seen; button = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (swotch === 1'b1) state = 2'b10;
    end
    chk("insp_press_sw", sw_seen - base, 1);
    ticks(15);
    chk("hold_ready", int'(ready), 1);
    base = sw_seen; button = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (swotch === 1'b1) state = 2'b11;
    end
    chk("hold_release_sw", sw_seen - base, 1);
    chk("hold_ready_off", int'(ready), 0);

    // Stop from Timing: latency from button rise to swotch
    state = 2'b11; button = 1'b1; t_sw = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (swotch === 1'b1 && t_sw < 0) t_sw = k;
    end
    chk("timing_press_lat", t_sw, DEB + 3);
    base = sw_seen; button = 1'b0; ticks(10);
    chk("timing_release_sw", sw_seen - base, 0);

    // Early release in Holdstart, then a long hold
    state = 2'b10; base = sw_seen; rdy_seen = 0;
    button = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); if (ready === 1'b1) rdy_seen++; end
    button = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); if (ready === 1'b1) rdy_seen++; end
`ifdef HOLD_CHECK_EN
    chk("early_release_sw", sw_seen - base, 0);
    chk("early_ready", rdy_seen, 0);
`else
    chk("early_release_sw", sw_seen - base, 1);
`endif
    base = sw_seen; button = 1'b1; ticks(18);
    button = 1'b0; ticks(10);
    chk("long_hold_sw", sw_seen - base, 1);

    // Random button segments, state changes and occasional reset
    for (int seg = 0; seg < 400; seg++) begin
      button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) state = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 39) == 0);
      for (int k = 0, n = $urandom_range(1, 16); k < n; k++) begin
        tick();
        reset = 1'b0;
        if ($urandom_range(0, 15) == 0) state = 2'($urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
